// File: rtl/framestore_arbiter.sv
// framestore_arbiter: round-robin arbiter of two frame readers and one writer onto one memory command channel
//   clk, rst (async, active-low)
//   reader side : rd_addr_empty/rd_addr_en/rd_addr_valid/rd_addr (2 x 22-bit),
//                 rdr_dta_almost_full/rdr_dta_en/rdr_dta (shared 64-bit return data)
//   writer side : wr_empty/wr_en/wr_valid/wr_addr/wr_dta
//   memory side : mem_cmd_valid/ready/write/addr/dta, mem_rd_valid/mem_rd_dta (in command order)
//   status      : busy, error (sticky until reset)
module framestore_arbiter #(
    parameter int tag_depth      = 3,
    parameter int per_reader_max = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rd_addr_empty,
    output logic [1:0]  rd_addr_en,
    input  logic [1:0]  rd_addr_valid,
    input  logic [43:0] rd_addr,
    input  logic [1:0]  rdr_dta_almost_full,
    output logic [1:0]  rdr_dta_en,
    output logic [63:0] rdr_dta,
    input  logic        wr_empty,
    output logic        wr_en,
    input  logic        wr_valid,
    input  logic [21:0] wr_addr,
    input  logic [63:0] wr_dta,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic        mem_cmd_write,
    output logic [21:0] mem_cmd_addr,
    output logic [63:0] mem_cmd_dta,
    input  logic        mem_rd_valid,
    input  logic [63:0] mem_rd_dta,
    output logic        busy,
    output logic        error
);
    localparam logic [1:0] IDLE = 2'd0, POP = 2'd1, WAIT = 2'd2, ISSUE = 2'd3;
    localparam int cw = $clog2(per_reader_max + 1);
    localparam logic [tag_depth:0] tag_cap = {1'b1, {tag_depth{1'b0}}};
    localparam logic [cw-1:0] rd_cap = cw'(per_reader_max);

    logic [1:0] state, win, ptr, win_n, c1, c2, inc, dec;
    logic [2:0] el;
    logic wv, push, pop, tag_full;
    logic [1:0][cw-1:0] out_cnt;
    logic [tag_depth:0] total;
    // one bit per outstanding read: which reader it belongs to
    logic [(1 << tag_depth)-1:0] tag_mem;
    logic [tag_depth-1:0] wp, rp;

    always_comb begin
        tag_full = total == tag_cap;
        el[0] = !rd_addr_empty[0] && !rdr_dta_almost_full[0] && out_cnt[0] < rd_cap && !tag_full;
        el[1] = !rd_addr_empty[1] && !rdr_dta_almost_full[1] && out_cnt[1] < rd_cap && !tag_full;
        el[2] = !wr_empty;
        // search order starts just after the last granted requester (0 -> 1 -> 2 -> 0)
        c1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
        c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
        win_n = el[c1] ? c1 : el[c2] ? c2 : ptr;
        wv = win == 2'd2 ? wr_valid : rd_addr_valid[win[0]];
        push = state == ISSUE && mem_cmd_ready && !mem_cmd_write;
        // a return with nothing outstanding is dropped and leaves every counter alone
        pop = mem_rd_valid && total != '0;
        inc = push ? (win[0] ? 2'b10 : 2'b01) : 2'b00;
        dec = pop ? (tag_mem[rp] ? 2'b10 : 2'b01) : 2'b00;
    end

    assign mem_cmd_valid = state == ISSUE;
    assign rd_addr_en = state == POP && win != 2'd2 ? (win[0] ? 2'b10 : 2'b01) : 2'b00;
    assign wr_en = state == POP && win == 2'd2;
    assign busy = state != IDLE || total != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            win <= 2'd0;
            ptr <= 2'd2;
            out_cnt <= '0;
            total <= '0;
            tag_mem <= '0;
            wp <= '0;
            rp <= '0;
            mem_cmd_addr <= '0;
            mem_cmd_dta <= '0;
            mem_cmd_write <= 1'b0;
            rdr_dta <= '0;
            rdr_dta_en <= '0;
            error <= 1'b0;
        end else begin
            if (state == IDLE && |el) begin
                win <= win_n;
                ptr <= win_n;
                state <= POP;
            end
            if (state == POP) state <= WAIT;
            if (state == WAIT) begin
                state <= wv ? ISSUE : IDLE;
                if (wv) begin
                    mem_cmd_addr <= win == 2'd2 ? wr_addr : win[0] ? rd_addr[43:22] : rd_addr[21:0];
                    mem_cmd_dta <= win == 2'd2 ? wr_dta : 64'd0;
                    mem_cmd_write <= win == 2'd2;
                end
            end
            if (state == ISSUE && mem_cmd_ready) state <= IDLE;
            if ((state == WAIT && !wv) || (mem_rd_valid && total == '0)) error <= 1'b1;
            if (push) begin
                tag_mem[wp] <= win[0];
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
                rdr_dta <= mem_rd_dta;
            end
            rdr_dta_en <= dec;
            total <= push && !pop ? total + 1'b1 : pop && !push ? total - 1'b1 : total;
            for (int i = 0; i < 2; i++)
                out_cnt[i] <= inc[i] && !dec[i] ? out_cnt[i] + 1'b1 :
                              dec[i] && !inc[i] ? out_cnt[i] - 1'b1 : out_cnt[i];
        end
    end
endmodule
